// File: rtl/conv_out_reader_if.sv
// Result stream from conv_out_reader to the host side.
// Valid/ready handshake carrying a 16-bit word and a last-word tag.
interface conv_out_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/conv_out_reader.sv
// Streams packed convolution results from the output SRAM read port
// to the host with valid/ready backpressure, interlocked with dut_busy.
module conv_out_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  rd_start,
    input  logic [11:0]           rd_base,
    input  logic [11:0]           rd_count,
    input  logic                  dut_busy,
    output logic [11:0]           rdr_sram_read_address,
    input  logic [15:0]           sram_rdr_read_data,
    conv_out_reader_if.master     dout,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  rd_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] remain_q, remain_d;
    logic        iss_q, iss_d;
    logic        iss_last_q, iss_last_d;
    logic        ret_q, ret_last_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [16:0]   head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW+1:0] occ;
    logic          push, pop, can_issue;

    assign head                  = mem_q[rd_ptr_q];
    assign dout.out_valid        = (cnt_q != '0);
    assign dout.out_data         = head[15:0];
    assign dout.out_last         = dout.out_valid & head[16];
    assign rdr_sram_read_address = addr_q;
    assign rd_busy               = busy_q;
    assign rd_done               = done_q;
    assign rd_err                = err_q;

    // Reads issued but not yet pushed count against the free space.
    always_comb begin
        push      = ret_q;
        pop       = dout.out_valid & dout.out_ready;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        occ       = {1'b0, cnt_q} + (AW+2)'(iss_q)
                  + (AW+2)'(ret_q) - (AW+2)'(pop);
        can_issue = occ < (AW+2)'(FIFO_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        busy_d     = busy_q;
        iss_d      = 1'b0;
        iss_last_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_start) begin
                    if (dut_busy) begin
                        err_d = 1'b1;
                    end else if (rd_count == 12'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d     = 1'b1;
                        addr_d     = rd_base;
                        iss_d      = 1'b1;
                        iss_last_d = (rd_count == 12'd1);
                        remain_d   = rd_count - 12'd1;
                        state_d    = (rd_count == 12'd1) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    addr_d     = addr_q + 12'd1;
                    iss_d      = 1'b1;
                    iss_last_d = (remain_q == 12'd1);
                    remain_d   = remain_q - 12'd1;
                    if (remain_q == 12'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!iss_q && !ret_q && cnt_d == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            ret_q      <= 1'b0;
            ret_last_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            ret_q      <= iss_q;
            ret_last_q <= iss_last_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            if (push) mem_q[wr_ptr_q] <= {ret_last_q, sram_rdr_read_data};
        end
    end
endmodule
